rv_muldiv_unit: RTL
===================

// Module: rv_muldiv_unit
// PURPOSE
//  Multi-cycle M-extension execute unit: MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
//  Sits beside the single-cycle ALU in EX stage; the pipeline stalls on in_ready/out_valid.
//  Parametrised operand width; iterative shift-add multiply and restoring divide.
// PARAMETERS
//  XLEN   32  operand/result width (>=8, even)
//  CNT_W  $clog2(XLEN)+1  iteration counter width (derived, do not override)
// PORTS
//  clk        in   1     clock, rising edge
//  rst_n      in   1     asynchronous active-low reset
//  flush      in   1     synchronous abort of any operation in flight
//  in_valid   in   1     request valid
//  in_ready   out  1     unit can accept request (high only in IDLE)
//  op         in   3     muldiv_op_e, encoding = RISC-V funct3 (0 MUL..7 REMU)
//  dataA      in   XLEN  rs1 operand
//  dataB      in   XLEN  rs2 operand
//  out_valid  out  1     result valid, held until out_ready
//  out_ready  in   1     consumer accepts result
//  dataD      out  XLEN  result
//  busy       out  1     state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE, in_ready=1, out_valid=0, busy=0, dataD=0, counter=0, all datapath regs 0.
//  FSM: IDLE -> CALC on in_valid&&in_ready (operands, op, sign flags latched that edge).
//   CALC: one iteration per cycle, counter counts XLEN..1; at 0 -> DONE.
//   DONE: out_valid=1, dataD stable; out_ready -> IDLE. No new accept in DONE (no overlap).
//   IDLE -> DONE directly for special cases below (result computed at accept edge).
//  Latency: iterative ops out_valid on cycle accept+XLEN+1; special cases accept+1.
//  Multiply: operands converted to magnitude per op signedness (MUL/MULH signed x signed,
//   MULHSU signed x unsigned, MULHU unsigned); 2*XLEN product, negated if signs differ;
//   MUL returns product[XLEN-1:0], MULH* return product[2*XLEN-1:XLEN].
//  Divide: magnitudes restoring-divided; quotient negated if signs differ (DIV), remainder
//   takes sign of dividend (REM). DIVU/REMU unsigned.
//  Special cases (no iteration): dataB==0 -> DIV/DIVU = all ones, REM/REMU = dataA;
//   DIV/REM with dataA=most-negative, dataB=-1 -> DIV = most-negative, REM = 0.
//  flush: any state -> IDLE next edge, out_valid=0; flush with in_valid same cycle: not
//   accepted. flush has priority over out_ready and accept.
//  Reset asserted mid-operation: immediate return to reset values; no partial result.
//  out_valid&&!out_ready: dataD and out_valid hold indefinitely.
// CONFIGURATION
//  RV_MULDIV_FAST_MUL_EN defined: MUL* ops use one combinational 2*XLEN multiplier and go
//   IDLE->DONE (latency 1, same as special cases); divide path unchanged.
//  Undefined: MUL* ops iterate XLEN cycles via shift-add like divide (latency XLEN+1).
// STRUCTURE
//  Package rv_muldiv_pkg: typedef enum logic [2:0] muldiv_op_e {MUL,MULH,MULHSU,MULHU,
//   DIV,DIVU,REM,REMU}; typedef enum state_e {IDLE,CALC,DONE}; helper fn is_signed_a/b.
//  Sub-module rv_div_core: restoring divide step (remainder/quotient regs, 1 bit/cycle,
//   start/done); multiply step and sign fix-up stay in rv_muldiv_unit.
// TESTING (XLEN=32)
//  MUL 7 x -3 -> dataD=0xFFFFFFEB; out_valid at accept+33 (accept+1 with FAST_MUL_EN).
//  MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF;
//   MULHU same operands -> 0xFFFFFFFE.
//  DIV -7/2 -> 0xFFFFFFFD, REM -7/2 -> 0xFFFFFFFF, DIVU 100/7 -> 14, REMU 100/7 -> 2,
//   each out_valid at accept+33.
//  DIV x/0 -> 0xFFFFFFFF, REMU 5/0 -> 5, DIV 0x80000000/-1 -> 0x80000000, REM same -> 0;
//   all at accept+1.
//  Hold out_ready=0 10 cycles in DONE -> dataD/out_valid stable, in_ready=0; then release.
//  flush at CALC cycle 10, and rst_n low at CALC cycle 5 -> IDLE, out_valid never rises;
//   next DIVU 9/3 -> 3 correct.

Source files
------------

// File: rtl/rv_muldiv_pkg.sv
// rv_muldiv_pkg: shared types and helpers for the M-extension multiply/divide unit.
package rv_muldiv_pkg;

    // Encoding matches RISC-V funct3 for the M extension.
    typedef enum logic [2:0] {
        MUL    = 3'd0,
        MULH   = 3'd1,
        MULHSU = 3'd2,
        MULHU  = 3'd3,
        DIV    = 3'd4,
        DIVU   = 3'd5,
        REM    = 3'd6,
        REMU   = 3'd7
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    // rs1 is treated as two's complement for these ops.
    function automatic logic is_signed_a(input muldiv_op_e op);
        return (op == MUL) || (op == MULH) || (op == MULHSU) || (op == DIV) || (op == REM);
    endfunction

    // rs2 is treated as two's complement for these ops.
    function automatic logic is_signed_b(input muldiv_op_e op);
        return (op == MUL) || (op == MULH) || (op == DIV) || (op == REM);
    endfunction

endpackage

// File: rtl/rv_div_core.sv
// rv_div_core: unsigned restoring divider, one quotient bit per step.
// start loads dividend/divisor magnitudes; step shifts in one bit. The step
// outputs expose the result of the current step so the caller can capture
// the final quotient/remainder on the same edge as the last iteration.
module rv_div_core #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            step,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quo_step,
    output logic [XLEN-1:0] rem_step
);
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic            fits;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        fits = {rem_q, quo_q[XLEN-1]} >= {1'b0, dvs_q};
        if (fits) begin
            rem_step = {rem_q[XLEN-2:0], quo_q[XLEN-1]} - dvs_q;
            quo_step = {quo_q[XLEN-2:0], 1'b1};
        end else begin
            rem_step = {rem_q[XLEN-2:0], quo_q[XLEN-1]};
            quo_step = {quo_q[XLEN-2:0], 1'b0};
        end
    end

    // Load on start, advance on step, otherwise hold.
    always_comb begin
        rem_d = rem_q;
        quo_d = quo_q;
        dvs_d = dvs_q;
        if (start) begin
            rem_d = '0;
            quo_d = dividend;
            dvs_d = divisor;
        end else if (step) begin
            rem_d = rem_step;
            quo_d = quo_step;
        end
    end

    // Divider registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            dvs_q <= dvs_d;
        end
    end

endmodule

// File: rtl/rv_muldiv_unit.sv
// rv_muldiv_unit: multi-cycle RISC-V M-extension execute unit.
// Iterative shift-add multiply, restoring divide (rv_div_core), sign fix-up.
// Optional macro RV_MULDIV_FAST_MUL_EN: multiplies use one combinational
// multiplier and complete IDLE->DONE; divide path is unaffected.
//
// state | meaning
// IDLE  | ready for a request
// CALC  | iterating, one bit per cycle, cnt_q counts XLEN..1
// DONE  | result valid on dataD, held until out_ready
module rv_muldiv_unit
    import rv_muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  muldiv_op_e      op,
    input  logic [XLEN-1:0] dataA,
    input  logic [XLEN-1:0] dataB,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] dataD,
    output logic            busy
);
    localparam int CNT_W = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    muldiv_op_e        op_q, op_d;
    logic              neg_q, neg_d;
    logic [XLEN-1:0]   mcand_q, mcand_d;
    logic [2*XLEN-1:0] prod_q, prod_d;
    logic [XLEN-1:0]   dataD_q, dataD_d;

    logic              accept, sa, sb, is_div, special, fast;
    logic [XLEN-1:0]   mag_a, mag_b, special_res, fast_res, iter_res, div_sel;
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] prod_step, prod_fix;
    logic              div_start, div_step;
    logic [XLEN-1:0]   quo_step, rem_step;

    // Request decode: magnitudes, special cases and the optional fast multiply.
    always_comb begin
        accept  = in_valid && (state_q == IDLE) && !flush;
        sa      = is_signed_a(op) && dataA[XLEN-1];
        sb      = is_signed_b(op) && dataB[XLEN-1];
        mag_a   = sa ? (~dataA + 1'b1) : dataA;
        mag_b   = sb ? (~dataB + 1'b1) : dataB;
        is_div  = op[2];
        special = 1'b0;
        special_res = '0;
        if (is_div && (dataB == '0)) begin
            special     = 1'b1;
            special_res = op[1] ? dataA : '1;
        end else if (((op == DIV) || (op == REM)) && (dataA == MOST_NEG) && (dataB == '1)) begin
            special     = 1'b1;
            special_res = op[1] ? '0 : MOST_NEG;
        end
`ifdef RV_MULDIV_FAST_MUL_EN
        fast     = !is_div;
        prod_fix = (sa ^ sb) ? -(mag_a * mag_b) : (mag_a * mag_b);
        fast_res = (op == MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
`else
        fast     = 1'b0;
        prod_fix = '0;
        fast_res = '0;
`endif
    end

    // One shift-add multiply step and final sign fix-up of the iterative result.
    always_comb begin
        mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
        prod_step = {mul_sum, prod_q[XLEN-1:1]};
        div_sel   = op_q[1] ? rem_step : quo_step;
        if (op_q[2]) begin
            iter_res = neg_q ? -div_sel : div_sel;
        end else if (op_q == MUL) begin
            iter_res = neg_q ? -prod_step[XLEN-1:0] : prod_step[XLEN-1:0];
        end else begin
            iter_res = neg_q ? (~prod_step[2*XLEN-1:XLEN] + {{(XLEN-1){1'b0}}, (prod_step[XLEN-1:0] == '0)})
                             : prod_step[2*XLEN-1:XLEN];
        end
    end

    // Next-state logic; flush overrides everything.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = (special || fast) ? DONE : CALC;
            CALC:    if (cnt_q == CNT_W'(1)) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    // Datapath register updates.
    always_comb begin
        cnt_d     = cnt_q;
        op_d      = op_q;
        neg_d     = neg_q;
        mcand_d   = mcand_q;
        prod_d    = prod_q;
        dataD_d   = dataD_q;
        div_start = 1'b0;
        div_step  = 1'b0;
        if (flush) begin
            cnt_d = '0;
        end else if (accept) begin
            op_d      = op;
            neg_d     = (is_div && op[1]) ? sa : (sa ^ sb);
            mcand_d   = mag_a;
            prod_d    = {{XLEN{1'b0}}, mag_b};
            cnt_d     = CNT_W'(XLEN);
            div_start = is_div && !special;
            if (special)   dataD_d = special_res;
            else if (fast) dataD_d = fast_res;
        end else if (state_q == CALC) begin
            cnt_d    = cnt_q - 1'b1;
            div_step = op_q[2];
            if (!op_q[2]) prod_d = prod_step;
            if (cnt_q == CNT_W'(1)) dataD_d = iter_res;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= MUL;
            neg_q   <= 1'b0;
            mcand_q <= '0;
            prod_q  <= '0;
            dataD_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
            mcand_q <= mcand_d;
            prod_q  <= prod_d;
            dataD_q <= dataD_d;
        end
    end

    // Handshake outputs decoded from state.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q != IDLE);
        dataD     = dataD_q;
    end

    rv_div_core #(.XLEN(XLEN)) u_div_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .step     (div_step),
        .dividend (mag_a),
        .divisor  (mag_b),
        .quo_step (quo_step),
        .rem_step (rem_step)
    );

endmodule
